// File: rtl/atm_pin_auth_ctrl.sv
`default_nettype none
// atm_pin_auth_ctrl -- card-insert/PIN-check session controller with retry limit,
// inactivity timeout and eject/retain termination. Rev 1.0
module atm_pin_auth_ctrl #(
  parameter int PIN_W       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] stored_pin,
  input  logic             cancel,
  input  logic             activity,
  input  logic             session_done,
  output logic             auth_ok,
  output logic             session_active,
  output logic             pin_err,
  output logic             eject_card,
  output logic             retain_card,
  output logic [3:0]       tries_left,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_PIN    = 3'd1,
    S_CHECK       = 3'd2,
    S_SESSION     = 3'd3,
    S_EJECT       = 3'd4,
    S_RETAIN      = 3'd5,
    S_WAIT_REMOVE = 3'd6
  } state_t;

  localparam logic [3:0]  C_MAX_TRIES    = 4'(MAX_TRIES);
  localparam logic [31:0] C_TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_timer;
  logic [PIN_W-1:0] r_pin;
  logic [3:0]       r_tries;
  logic             r_auth_ok;
  logic             r_session_active;
  logic             r_pin_err;
  logic             r_eject;
  logic             r_retain;

  logic w_timeout;
  logic w_match;
  logic w_timer_clr;
  logic w_timer_run;
  logic w_load_tries;
  logic w_dec_tries;
  logic w_capture;
  logic w_pin_err;
  logic w_auth_ok;

  assign w_timeout = (r_timer == C_TIMEOUT_LAST);
  assign w_match   = (r_pin == stored_pin);

  // Card removal outranks every other event in the card-holding states.
  always_comb begin
    w_next       = r_state;
    w_load_tries = 1'b0;
    w_dec_tries  = 1'b0;
    w_capture    = 1'b0;
    w_pin_err    = 1'b0;
    w_auth_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (card_in) begin
          w_next       = S_WAIT_PIN;
          w_load_tries = 1'b1;
        end
      end
      S_WAIT_PIN: begin
        if (!card_in) begin
          w_next = S_IDLE;
        end else if (cancel) begin
          w_next = S_EJECT;
        end else if (pin_valid) begin
          w_next    = S_CHECK;
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_next = S_EJECT;
        end
      end
      S_CHECK: begin
        if (!card_in) begin
          w_next = S_IDLE;
        end else if (w_match) begin
          w_next    = S_SESSION;
          w_auth_ok = 1'b1;
        end else if (r_tries > 4'd1) begin
          w_next      = S_WAIT_PIN;
          w_dec_tries = 1'b1;
          w_pin_err   = 1'b1;
        end else begin
          w_next      = S_RETAIN;
          w_dec_tries = 1'b1;
        end
      end
      S_SESSION: begin
        if (!card_in) begin
          w_next = S_IDLE;
        end else if (session_done || cancel) begin
          w_next = S_EJECT;
        end else if (w_timeout && !activity) begin
          w_next = S_EJECT;
        end
      end
      S_EJECT:  w_next = S_WAIT_REMOVE;
      S_RETAIN: w_next = S_WAIT_REMOVE;
      S_WAIT_REMOVE: begin
        if (!card_in) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_timer_clr = (w_next != r_state) || w_pin_err ||
                       ((r_state == S_SESSION) && activity);
  assign w_timer_run = (r_state == S_WAIT_PIN) || (r_state == S_SESSION);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timer only advances in the two states that can time out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_clr || !w_timer_run) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pin   <= '0;
      r_tries <= C_MAX_TRIES;
    end else begin
      if (w_capture) begin
        r_pin <= pin;
      end
      if (w_load_tries) begin
        r_tries <= C_MAX_TRIES;
      end else if (w_dec_tries && (r_tries != 4'd0)) begin
        r_tries <= r_tries - 4'd1;
      end
    end
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auth_ok        <= 1'b0;
      r_session_active <= 1'b0;
      r_pin_err        <= 1'b0;
      r_eject          <= 1'b0;
      r_retain         <= 1'b0;
    end else begin
      r_auth_ok        <= w_auth_ok;
      r_session_active <= (w_next == S_SESSION);
      r_pin_err        <= w_pin_err;
      r_eject          <= (w_next == S_EJECT);
      r_retain         <= (w_next == S_RETAIN);
    end
  end

  assign auth_ok        = r_auth_ok;
  assign session_active = r_session_active;
  assign pin_err        = r_pin_err;
  assign eject_card     = r_eject;
  assign retain_card    = r_retain;
  assign tries_left     = r_tries;
  assign state_dbg      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_atm_pin_auth_ctrl.sv
`default_nettype none
// tb_atm_pin_auth_ctrl -- directed and randomized sessions scored against an
// attempt-count model of the authentication rules. Rev 1.0
module tb_atm_pin_auth_ctrl;

  localparam int PIN_W       = 4;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 8;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_PIN    = 3'd1;
  localparam logic [2:0] ST_CHECK       = 3'd2;
  localparam logic [2:0] ST_SESSION     = 3'd3;
  localparam logic [2:0] ST_EJECT       = 3'd4;
  localparam logic [2:0] ST_RETAIN      = 3'd5;
  localparam logic [2:0] ST_WAIT_REMOVE = 3'd6;

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic             card_in      = 1'b0;
  logic             pin_valid    = 1'b0;
  logic [PIN_W-1:0] pin          = '0;
  logic [PIN_W-1:0] stored_pin   = '0;
  logic             cancel       = 1'b0;
  logic             activity     = 1'b0;
  logic             session_done = 1'b0;
  logic             auth_ok;
  logic             session_active;
  logic             pin_err;
  logic             eject_card;
  logic             retain_card;
  logic [3:0]       tries_left;
  logic [2:0]       state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  atm_pin_auth_ctrl #(
    .PIN_W       (PIN_W),
    .MAX_TRIES   (MAX_TRIES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .card_in        (card_in),
    .pin_valid      (pin_valid),
    .pin            (pin),
    .stored_pin     (stored_pin),
    .cancel         (cancel),
    .activity       (activity),
    .session_done   (session_done),
    .auth_ok        (auth_ok),
    .session_active (session_active),
    .pin_err        (pin_err),
    .eject_card     (eject_card),
    .retain_card    (retain_card),
    .tries_left     (tries_left),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("pulse_exclusive",
          {31'd0, ($countones({auth_ok, pin_err, eject_card, retain_card}) > 1)}, 32'd0);
  endtask

  // Packed as {auth_ok, pin_err, eject, retain, session_active, tries_left, state}.
  task automatic expect_out(input string tag, input logic a, e, j, r, s,
                            input logic [3:0] t, input logic [2:0] st);
    check(tag, {20'd0, auth_ok, pin_err, eject_card, retain_card, session_active, tries_left, state_dbg},
               {20'd0, a, e, j, r, s, t, st});
  endtask

  function automatic logic sel(input int which);
    logic v;
    case (which)
      0:       v = auth_ok;
      1:       v = pin_err;
      2:       v = eject_card;
      default: v = retain_card;
    endcase
    return v;
  endfunction

  task automatic wait_pulse(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (sel(which)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic insert_card(input logic [PIN_W-1:0] sp);
    stored_pin = sp;
    card_in    = 1'b1;
    step();
    expect_out("insert", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_WAIT_PIN);
  endtask

  // Leaves the bench looking at the CHECK cycle.
  task automatic strobe_pin(input logic [PIN_W-1:0] p);
    pin       = p;
    pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
  endtask

  // Outcome of the k-th consecutive wrong PIN on one card.
  task automatic expect_wrong(input string tag, input int k);
    int left;
    left = MAX_TRIES - k;
    if (left > 0)
      expect_out(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(left), ST_WAIT_PIN);
    else
      expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, ST_RETAIN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               n;
    int               wrong;
    int               how;
    int               exp_tries;
    logic [PIN_W-1:0] sp;
    logic [PIN_W-1:0] wp;

    reset = 1'b1;
    repeat (2) step();
    expect_out("reset_values", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);
    reset = 1'b0;
    step();
    expect_out("idle_no_card", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);

    // Good PIN, finish via session_done, card left in the reader for a while.
    insert_card(4'hA);
    strobe_pin(4'hA);
    expect_out("good_check", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_CHECK);
    step();
    expect_out("good_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    step();
    expect_out("good_session", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    expect_out("good_eject", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(MAX_TRIES), ST_EJECT);
    repeat (3) step();
    expect_out("hold_wait_remove", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_WAIT_REMOVE);
    card_in = 1'b0;
    step();
    expect_out("removed_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);

    // Lockout after MAX_TRIES wrong PINs.
    insert_card(4'hA);
    for (int k = 1; k <= MAX_TRIES; k++) begin
      strobe_pin(4'h3);
      step();
      expect_wrong("lockout", k);
    end
    step();
    expect_out("lock_wait_remove", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ST_WAIT_REMOVE);
    card_in = 1'b0;
    step();
    expect_out("lock_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ST_IDLE);

    // Recovery: two wrong, then correct; next insert reloads the counter.
    insert_card(4'h5);
    for (int k = 1; k <= 2; k++) begin
      strobe_pin(4'h3);
      step();
      expect_wrong("recover_wrong", k);
    end
    strobe_pin(4'h5);
    step();
    expect_out("recover_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES - 2), ST_SESSION);
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    step();
    card_in = 1'b0;
    step();
    insert_card(4'h5);

    // No input after insert: forced eject TIMEOUT_CYC cycles after WAIT_PIN entry.
    wait_pulse(2, 3 * TIMEOUT_CYC, n);
    check("waitpin_timeout_latency", n, TIMEOUT_CYC);
    step();
    card_in = 1'b0;
    step();

    // Activity every 5 cycles keeps the session open; silence then times it out.
    insert_card(4'h7);
    strobe_pin(4'h7);
    step();
    expect_out("keep_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      activity = 1'b1;
      step();
      activity = 1'b0;
      expect_out("keepalive", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    end
    wait_pulse(2, 3 * TIMEOUT_CYC, n);
    check("session_timeout_latency", n, TIMEOUT_CYC);
    step();
    card_in = 1'b0;
    step();

    // Activity exactly on the timeout cycle; later session_done on the timeout cycle.
    insert_card(4'h7);
    strobe_pin(4'h7);
    step();
    repeat (TIMEOUT_CYC - 1) step();
    activity = 1'b1;
    step();
    activity = 1'b0;
    expect_out("activity_on_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    repeat (TIMEOUT_CYC - 1) step();
    session_done = 1'b1;
    step();
    session_done = 1'b0;
    expect_out("done_on_timeout", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(MAX_TRIES), ST_EJECT);
    step();
    expect_out("single_eject", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_WAIT_REMOVE);
    card_in = 1'b0;
    step();

    // cancel outranks a simultaneous pin_valid.
    insert_card(4'h2);
    pin       = 4'h2;
    pin_valid = 1'b1;
    cancel    = 1'b1;
    step();
    pin_valid = 1'b0;
    cancel    = 1'b0;
    expect_out("cancel_over_pin", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(MAX_TRIES), ST_EJECT);
    step();
    card_in = 1'b0;
    step();

    // pin_valid on the timeout cycle is accepted; then card pulled in SESSION.
    insert_card(4'h2);
    repeat (TIMEOUT_CYC - 1) step();
    strobe_pin(4'h2);
    expect_out("pin_on_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_CHECK);
    step();
    expect_out("pin_on_timeout_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), ST_SESSION);
    card_in = 1'b0;
    step();
    expect_out("pull_in_session", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);

    // Card pulled during CHECK: straight to IDLE without any pulse.
    insert_card(4'h2);
    strobe_pin(4'h9);
    card_in = 1'b0;
    step();
    expect_out("pull_in_check", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);
    repeat (2) step();
    expect_out("pull_in_check_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);

    // Reset in SESSION with a partially used try counter.
    insert_card(4'hC);
    strobe_pin(4'h1);
    step();
    expect_wrong("reset_pre_wrong", 1);
    strobe_pin(4'hC);
    step();
    expect_out("reset_pre_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(MAX_TRIES - 1), ST_SESSION);
    step();
    reset = 1'b1;
    step();
    expect_out("reset_in_session", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);
    card_in = 1'b0;
    reset   = 1'b0;
    step();
    expect_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(MAX_TRIES), ST_IDLE);

    // Randomized sessions: outcome depends only on the number of wrong attempts.
    for (int s = 0; s < 24; s++) begin
      sp    = 4'($urandom);
      wrong = $urandom_range(0, MAX_TRIES + 1);
      insert_card(sp);
      for (int k = 1; k <= wrong && k <= MAX_TRIES; k++) begin
        repeat ($urandom_range(0, TIMEOUT_CYC - 1)) step();
        wp = sp ^ 4'($urandom_range(1, 15));
        strobe_pin(wp);
        step();
        expect_wrong("rand_wrong", k);
      end
      exp_tries = (wrong >= MAX_TRIES) ? 0 : MAX_TRIES - wrong;
      if (wrong < MAX_TRIES) begin
        repeat ($urandom_range(0, TIMEOUT_CYC - 1)) step();
        strobe_pin(sp);
        step();
        expect_out("rand_auth", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(exp_tries), ST_SESSION);
        how = $urandom_range(0, 2);
        if (how == 2) begin
          wait_pulse(2, 3 * TIMEOUT_CYC, n);
          check("rand_timeout_latency", n, TIMEOUT_CYC);
        end else begin
          repeat ($urandom_range(0, TIMEOUT_CYC - 1)) step();
          if (how == 0) session_done = 1'b1;
          else          cancel       = 1'b1;
          step();
          session_done = 1'b0;
          cancel       = 1'b0;
          expect_out("rand_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(exp_tries), ST_EJECT);
        end
      end
      step();
      card_in = 1'b0;
      step();
      expect_out("rand_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(exp_tries), ST_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm_pin_auth_ctrl.md
Name: atm_pin_auth_ctrl

Overview:
- Session and authentication controller placed in front of the ATM transaction state machine.
- Handles the card-insert to PIN-check sequence, with a retry counter and an inactivity timeout.
- Issues a one-cycle grant (`auth_ok`) to the transaction FSM and holds `session_active` for the rest of the session.
- Ends every session with either a card eject or a card retain command to the card mechanism.

Parameters:
- PIN_W, 4, width of the entered PIN and the stored PIN.
- MAX_TRIES, 3, wrong-PIN attempts allowed before the card is retained. Legal range 1..15.
- TIMEOUT_CYC, 1000, idle cycles allowed in WAIT_PIN or SESSION before a forced eject. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- card_in  input  1  level; card present in the reader.
- pin_valid  input  1  one-cycle strobe; `pin` holds a completed entry.
- pin  input  PIN_W  entered PIN, sampled when pin_valid=1.
- stored_pin  input  PIN_W  PIN of the inserted card; stable while card_in=1.
- cancel  input  1  user cancel key, level or pulse.
- activity  input  1  pulse from the transaction FSM on any user action; restarts the session timer.
- session_done  input  1  pulse from the transaction FSM; the user chose to finish.
- auth_ok  output  1  one-cycle pulse on a successful PIN match.
- session_active  output  1  high for the whole time the FSM is in SESSION.
- pin_err  output  1  one-cycle pulse on a wrong PIN while tries remain.
- eject_card  output  1  one-cycle pulse commanding card eject.
- retain_card  output  1  one-cycle pulse commanding card capture.
- tries_left  output  4  remaining attempts.
- state_dbg  output  3  current state encoding.

Behaviour:
- All outputs are registered. Reset values:
  - auth_ok, session_active, pin_err, eject_card and retain_card are 0.
  - tries_left = MAX_TRIES.
  - state = IDLE (encoding 0).
- State encodings: IDLE=0, WAIT_PIN=1, CHECK=2, SESSION=3, EJECT=4, RETAIN=5, WAIT_REMOVE=6.
- Timer: a 32-bit counter, cleared on every state entry, on pin_err, and on activity while in SESSION. Timeout fires when timer == TIMEOUT_CYC-1.
- IDLE:
  - card_in=1 → WAIT_PIN; tries_left loads MAX_TRIES.
- WAIT_PIN, priority order:
  - cancel → EJECT.
  - else pin_valid → CHECK, capturing pin into an internal register.
  - else timeout → EJECT.
  - pin_valid on the timeout cycle is accepted.
- CHECK (exactly one cycle), comparing the captured pin against stored_pin:
  - Match → SESSION; auth_ok=1 in the first SESSION cycle, i.e. 2 cycles after pin_valid is sampled.
  - Mismatch with tries_left > 1 → tries_left decrements, pin_err pulses, → WAIT_PIN.
  - Mismatch with tries_left == 1 → tries_left becomes 0, → RETAIN.
- SESSION:
  - session_active=1.
  - session_done or cancel → EJECT.
  - timeout → EJECT.
  - activity on the timeout cycle suppresses the timeout.
- EJECT: eject_card=1 for exactly one cycle, → WAIT_REMOVE.
- RETAIN: retain_card=1 for exactly one cycle, → WAIT_REMOVE.
- WAIT_REMOVE:
  - Stays until card_in=0, then → IDLE.
  - Never re-enters WAIT_PIN on the same card, even if card_in stays high.
- Card pulled early:
  - card_in=0 in WAIT_PIN, CHECK or SESSION → IDLE next cycle.
  - No eject or retain pulse; session_active drops.
  - tries_left reloads MAX_TRIES on the next insert.
- Reset mid-session: returns to IDLE on the next edge and clears all pulses. No eject is issued; the mechanism handles the card itself.
- Pulse exclusivity: auth_ok, pin_err, eject_card and retain_card are never high in the same cycle.
- Comparison width: the compare is over exactly PIN_W bits. tries_left never underflows below 0.

Test Plan:
- Good PIN: insert card, stored_pin=4'hA, pin_valid with pin=4'hA → CHECK next cycle, auth_ok pulse 2 cycles after the strobe, session_active=1; session_done → eject_card pulse; card_in=0 → IDLE.
- Lockout: three wrong PINs (4'h3) with MAX_TRIES=3 → pin_err pulses with tries_left 2 then 1, third attempt → retain_card pulse, tries_left=0, no auth_ok.
- Recovery: two wrong PINs, then correct → auth_ok, tries_left stays 1; next card insert reloads tries_left=3.
- Timeout: TIMEOUT_CYC=8, no input after insert → eject_card 8 cycles after WAIT_PIN entry; in SESSION, activity every 5 cycles keeps the session alive indefinitely.
- Priorities: cancel and pin_valid in the same cycle → EJECT, no CHECK; session_done and timeout in the same cycle → single eject_card pulse.
- Abort: card_in dropped in CHECK → IDLE with no pulses; reset asserted in SESSION → state_dbg=0 and all outputs at reset values the next cycle.
